delay_m_flow_ctrl: RTL and testbench

Valid/ready flow controller that puts a free-running, non-stallable `delay_m` matrix pipeline behind a handshake interface. It tags each accepted matrix with a valid bit that travels alongside the pipeline and captures emerging matrices into an output FIFO. A credit counter throttles input so the FIFO never overflows under downstream backpressure. It sits between an upstream matrix producer and a downstream consumer, with `delay_m` instantiated beside it.

---
 rtl/delay_m_flow_ctrl.sv | 131 +++++++++++++
 tb/tb_delay_m_flow_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_m_flow_ctrl.sv
// Valid/ready wrapper around a free-running delay_m matrix pipeline.
// Tags ride beside the pipeline; credits keep the output FIFO from overflowing.
module delay_m_flow_ctrl #(
  parameter int DELAY = 1,
  parameter int WIDTH = 1,
  parameter int R     = 1,
  parameter int C     = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data [R][C],
  output logic [WIDTH-1:0] pipe_a [R][C],
  input  logic [WIDTH-1:0] pipe_c [R][C],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data [R][C],
  output logic [CW-1:0]    inflight,
  output logic [CW-1:0]    occupancy,
  output logic             err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DELAY-1:0] tag;
  logic [CW-1:0]    credits;
  logic [CW-1:0]    inflight_q;
  logic [CW-1:0]    occ_q;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH][R][C];
  logic             err_q;

  logic accept;
  logic push;
  logic pop;
  logic full;
  logic wr;

  assign in_ready  = (credits != '0) & ~flush;
  assign accept    = in_valid & in_ready;
  assign push      = tag[DELAY-1];
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (occ_q == CW'(DEPTH));
  // A push into a full FIFO only lands if a pop frees the slot.
  assign wr        = push & (~full | pop) & ~flush;

  assign inflight  = inflight_q;
  assign occupancy = occ_q;
  assign err       = err_q;

  always_comb begin
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        pipe_a[r][c]   = in_data[r][c];
        out_data[r][c] = out_valid ? mem[rptr][r][c] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag <= '0;
    end else if (flush) begin
      tag <= '0;
    end else begin
      tag[0] <= accept;
      for (int i = 1; i < DELAY; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credits    <= CW'(DEPTH);
      inflight_q <= '0;
      occ_q      <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else if (flush) begin
      credits    <= CW'(DEPTH);
      inflight_q <= '0;
      occ_q      <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
      unique case ({accept, push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
      unique case ({wr, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (wr) begin
        wptr <= (wptr == PW'(DEPTH-1)) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == PW'(DEPTH-1)) ? '0 : rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (push & full & ~pop & ~flush) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= pipe_c;
    end
  end

endmodule

// File: tb/tb_delay_m_flow_ctrl.sv
// Directed bench for delay_m_flow_ctrl.
// A 3-stage shift register stands in for delay_m.
module tb_delay_m_flow_ctrl;

  localparam int DELAY = 3;
  localparam int WIDTH = 8;
  localparam int R     = 2;
  localparam int C     = 2;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data [R][C];
  logic [WIDTH-1:0] pipe_a [R][C];
  logic [WIDTH-1:0] pipe_c [R][C];
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data [R][C];
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    occupancy;
  logic             err;

  logic [WIDTH-1:0] s0 [R][C];
  logic [WIDTH-1:0] s1 [R][C];
  logic [WIDTH-1:0] s2 [R][C];
  logic [31:0]      out_flat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s0 <= pipe_a;
    s1 <= s0;
    s2 <= s1;
  end
  assign pipe_c = s2;

  assign out_flat = {out_data[0][0], out_data[0][1],
                     out_data[1][0], out_data[1][1]};

  delay_m_flow_ctrl #(
    .DELAY(DELAY), .WIDTH(WIDTH), .R(R), .C(C),
    .DEPTH(DEPTH), .CW(CW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .pipe_a(pipe_a),
    .pipe_c(pipe_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .inflight(inflight),
    .occupancy(occupancy),
    .err(err)
  );

  function automatic logic [31:0] exp_m(input logic [7:0] b);
    logic [7:0] b1, b2, b3;
    b1 = b + 8'd1;
    b2 = b + 8'd2;
    b3 = b + 8'd3;
    return {b, b1, b2, b3};
  endfunction

  task automatic set_in(input logic [7:0] b);
    in_data[0][0] = b;
    in_data[0][1] = b + 8'd1;
    in_data[1][0] = b + 8'd2;
    in_data[1][1] = b + 8'd3;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_in(8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
    end
    checks++;
    if (occupancy !== '0) begin
      errors++;
      $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
    end
    checks++;
    if (inflight !== '0) begin
      errors++;
      $display("FAIL reset_inflight: got %0d expected 0", inflight);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %0b expected 0", err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
    end
    checks++;
    if (out_flat !== 32'h0) begin
      errors++;
      $display("FAIL reset_out_data: got %0h expected 0", out_flat);
    end
  endtask

  task automatic test_single;
    tick;
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_in(8'd1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_in_ready: got %0b expected 1", in_ready);
    end
    for (int k = 1; k <= 6; k++) begin
      tick;
      in_valid = 1'b0;
      @(negedge clk);
      if (k <= 3) begin
        checks++;
        if (inflight !== CW'(1)) begin
          errors++;
          $display("FAIL single_inflight c%0d: got %0d expected 1",
                   k, inflight);
        end
      end
      checks++;
      if (out_valid !== (k == 4)) begin
        errors++;
        $display("FAIL single_out_valid c%0d: got %0b expected %0b",
                 k, out_valid, (k == 4));
      end
      if (k == 4) begin
        checks++;
        if (out_flat !== 32'h01020304) begin
          errors++;
          $display("FAIL single_out_data: got %0h expected 01020304",
                   out_flat);
        end
      end
    end
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int k = 0; k < 28; k++) begin
      tick;
      in_valid = (k < 20);
      set_in(8'(k));
      @(negedge clk);
      if (k < 20) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_in_ready c%0d: got %0b expected 1",
                   k, in_ready);
        end
      end
      checks++;
      if (out_valid !== (k >= 4 && k < 24)) begin
        errors++;
        $display("FAIL stream_out_valid c%0d: got %0b expected %0b",
                 k, out_valid, (k >= 4 && k < 24));
      end
      if (k >= 4 && k < 24) begin
        checks++;
        if (out_flat !== exp_m(8'(k - 4))) begin
          errors++;
          $display("FAIL stream_out_data c%0d: got %0h expected %0h",
                   k, out_flat, exp_m(8'(k - 4)));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    int accepts;
    accepts = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      in_valid = 1'b1;
      set_in(8'(100 + 4*k));
      @(negedge clk);
      if (in_valid && in_ready) accepts++;
    end
    checks++;
    if (accepts !== 5) begin
      errors++;
      $display("FAIL bp_accepts: got %0d expected 5", accepts);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready_low: got %0b expected 0", in_ready);
    end
    checks++;
    if (occupancy !== CW'(5)) begin
      errors++;
      $display("FAIL bp_occupancy: got %0d expected 5", occupancy);
    end
    for (int m = 0; m < 6; m++) begin
      tick;
      out_ready = 1'b1;
      if (m >= 1) in_valid = 1'b0;
      @(negedge clk);
      if (m <= 1) begin
        checks++;
        if (in_ready !== (m == 1)) begin
          errors++;
          $display("FAIL bp_in_ready c%0d: got %0b expected %0b",
                   20 + m, in_ready, (m == 1));
        end
      end
      checks++;
      if (out_valid !== (m < 5)) begin
        errors++;
        $display("FAIL bp_out_valid c%0d: got %0b expected %0b",
                 20 + m, out_valid, (m < 5));
      end
      if (m < 5) begin
        checks++;
        if (out_flat !== exp_m(8'(100 + 4*m))) begin
          errors++;
          $display("FAIL bp_out_data c%0d: got %0h expected %0h",
                   20 + m, out_flat, exp_m(8'(100 + 4*m)));
        end
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL bp_err: got %0b expected 0", err);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      in_valid = (k < 4);
      set_in(8'(200 + 4*k));
      @(negedge clk);
    end
    tick;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (occupancy !== CW'(2) || inflight !== CW'(2)) begin
      errors++;
      $display("FAIL flush_pre occ/infl: got %0d/%0d expected 2/2",
               occupancy, inflight);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %0b expected 0", in_ready);
    end
    tick;
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (occupancy !== '0 || inflight !== '0) begin
      errors++;
      $display("FAIL flush_post occ/infl: got %0d/%0d expected 0/0",
               occupancy, inflight);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_post_in_ready: got %0b expected 1", in_ready);
    end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        tick;
        @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_stray c%0d: got %0b expected 0", k, out_valid);
      end
    end
    tick;
    in_valid = 1'b1;
    set_in(8'd40);
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      tick;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 4)) begin
        errors++;
        $display("FAIL flush_after_valid c%0d: got %0b expected %0b",
                 k, out_valid, (k == 4));
      end
      if (k == 4) begin
        checks++;
        if (out_flat !== exp_m(8'd40)) begin
          errors++;
          $display("FAIL flush_after_data: got %0h expected %0h",
                   out_flat, exp_m(8'd40));
        end
      end
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      in_valid = 1'b1;
      set_in(8'(60 + k));
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || inflight !== CW'(3)) begin
      errors++;
      $display("FAIL areset_pre valid/infl: got %0b/%0d expected 1/3",
               out_valid, inflight);
    end
    #1;
    rstn = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_flat !== 32'h0) begin
      errors++;
      $display("FAIL areset_out: got %0b/%0h expected 0/0",
               out_valid, out_flat);
    end
    checks++;
    if (occupancy !== '0 || inflight !== '0) begin
      errors++;
      $display("FAIL areset_counts: got %0d/%0d expected 0/0",
               occupancy, inflight);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick;
    in_valid = 1'b1;
    set_in(8'd90);
    @(negedge clk);
    for (int k = 1; k <= 7; k++) begin
      tick;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 4)) begin
        errors++;
        $display("FAIL areset_after_valid c%0d: got %0b expected %0b",
                 k, out_valid, (k == 4));
      end
      if (k == 4) begin
        checks++;
        if (out_flat !== exp_m(8'd90)) begin
          errors++;
          $display("FAIL areset_after_data: got %0h expected %0h",
                   out_flat, exp_m(8'd90));
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stream;
    test_backpressure;
    test_flush;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
